// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its neighbours: hazard unit, EX redirect,
// instruction memory and the IF/ID register consumed by decode.
interface fetch_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stall_i;
  logic             branch_taken_i;
  logic [31:0]      branch_target_i;
  logic [31:0]      imem_addr_o;
  logic [31:0]      imem_rdata_i;
  logic [31:0]      if_id_pc_o;
  logic [31:0]      if_id_pc_plus4_o;
  logic [31:0]      if_id_instr_o;
  logic             if_id_valid_o;
  logic             halted_o;
  logic [CNT_W-1:0] fetch_count_o;

  // Fetch-stage side.
  modport master (
    input  stall_i,
    input  branch_taken_i,
    input  branch_target_i,
    input  imem_rdata_i,
    output imem_addr_o,
    output if_id_pc_o,
    output if_id_pc_plus4_o,
    output if_id_instr_o,
    output if_id_valid_o,
    output halted_o,
    output fetch_count_o
  );

  // Environment side: hazard unit, EX stage, instruction memory, decode.
  modport slave (
    output stall_i,
    output branch_taken_i,
    output branch_target_i,
    output imem_rdata_i,
    input  imem_addr_o,
    input  if_id_pc_o,
    input  if_id_pc_plus4_o,
    input  if_id_instr_o,
    input  if_id_valid_o,
    input  halted_o,
    input  fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, honours stalls
// and EX redirects, and parks on a HALT instruction until redirected.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFC00_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_stage_if.master bus
);

  typedef enum logic {
    S_FETCH,
    S_HALTED
  } state_e;

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      if_id_pc_q;
  logic [31:0]      if_id_pc_plus4_q;
  logic [31:0]      if_id_instr_q;
  logic             if_id_valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] fetch_count_q;

  logic [31:0]      pc_plus4_d;
  logic [31:0]      branch_pc_d;
  logic [CNT_W-1:0] fetch_count_d;
  logic             is_halt_d;

  always_comb begin
    pc_plus4_d    = pc_q + 32'd4;
    branch_pc_d   = {bus.branch_target_i[31:2], 2'b00};
    is_halt_d     = (bus.imem_rdata_i == HALT_INST);
    fetch_count_d = (fetch_count_q == '1) ? fetch_count_q
                                          : fetch_count_q + CNT_W'(1);
  end

  // Priority: reset > branch redirect > stall > state action.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_FETCH;
      pc_q             <= RESET_PC;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_instr_q    <= '0;
      if_id_valid_q    <= 1'b0;
      halted_q         <= 1'b0;
      fetch_count_q    <= '0;
    end else if (bus.branch_taken_i) begin
      // A HALT seen before the redirect was wrong-path, so fetch resumes.
      state_q          <= S_FETCH;
      pc_q             <= branch_pc_d;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_instr_q    <= '0;
      if_id_valid_q    <= 1'b0;
      halted_q         <= 1'b0;
    end else if (!bus.stall_i) begin
      case (state_q)
        S_FETCH: begin
          if_id_pc_q       <= pc_q;
          if_id_pc_plus4_q <= pc_plus4_d;
          if_id_instr_q    <= bus.imem_rdata_i;
          if_id_valid_q    <= 1'b1;
          fetch_count_q    <= fetch_count_d;
          if (is_halt_d) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end else begin
            pc_q <= pc_plus4_d;
          end
        end
        S_HALTED: begin
          if_id_pc_q       <= '0;
          if_id_pc_plus4_q <= '0;
          if_id_instr_q    <= '0;
          if_id_valid_q    <= 1'b0;
        end
        default: begin
          state_q  <= S_FETCH;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr_o      = pc_q;
  assign bus.if_id_pc_o       = if_id_pc_q;
  assign bus.if_id_pc_plus4_o = if_id_pc_plus4_q;
  assign bus.if_id_instr_o    = if_id_instr_q;
  assign bus.if_id_valid_o    = if_id_valid_q;
  assign bus.halted_o         = halted_q;
  assign bus.fetch_count_o    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage, checked against a
// cycle-level reference model of the fetch rules.
module tb_fetch_stage;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT    = 32'hFC00_0000;

  logic clk;
  logic rst;

  fetch_stage_if #(.CNT_W(CNT_W)) bus ();

  fetch_stage #(
    .RESET_PC (RST_PC),
    .HALT_INST(HALT),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit rand_mode = 1'b0;

  // Reference model state
  bit          m_init = 1'b0;
  logic [31:0] m_pc;
  bit          m_halted;
  logic [31:0] m_ipc, m_ipc4, m_instr;
  bit          m_valid;
  int          m_cnt;

  // Instruction memory contents
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h2001_0005;
    if (a == 32'h0000_0004) return 32'h2002_000A;
    if (a == 32'h0000_0040) return HALT;
    if (rand_mode && a[6:2] == 5'h0B) return HALT;
    return {8'h20, a[25:2], 2'b01};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ifid();
    m_ipc   = 32'h0;
    m_ipc4  = 32'h0;
    m_instr = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    logic [31:0] rd;
    if (m_init) check("imem_addr", bus.imem_addr_o, m_pc);
    rst                 = r;
    bus.stall_i         = s;
    bus.branch_taken_i  = b;
    bus.branch_target_i = t;
    bus.imem_rdata_i    = memfn(bus.imem_addr_o);
    rd = memfn(m_pc);
    @(posedge clk);
    #1;
    if (r) begin
      m_init   = 1'b1;
      m_pc     = RST_PC;
      m_halted = 1'b0;
      m_cnt    = 0;
      clear_ifid();
    end else if (b) begin
      m_pc     = t & 32'hFFFF_FFFC;
      m_halted = 1'b0;
      clear_ifid();
    end else if (s) begin
      // everything holds
    end else if (m_halted) begin
      clear_ifid();
    end else begin
      m_ipc   = m_pc;
      m_ipc4  = 32'((longint'(m_pc) + 64'd4) % 64'h1_0000_0000);
      m_instr = rd;
      m_valid = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (rd == HALT) m_halted = 1'b1;
      else            m_pc     = m_ipc4;
    end
    check("pc",          bus.imem_addr_o,            m_pc);
    check("if_id_pc",    bus.if_id_pc_o,             m_ipc);
    check("if_id_pc4",   bus.if_id_pc_plus4_o,       m_ipc4);
    check("if_id_instr", bus.if_id_instr_o,          m_instr);
    check("if_id_valid", {31'b0, bus.if_id_valid_o}, {31'b0, m_valid});
    check("halted",      {31'b0, bus.halted_o},      {31'b0, m_halted});
    check("fetch_count", 32'(bus.fetch_count_o),     32'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    rst                 = 1'b0;
    bus.stall_i         = 1'b0;
    bus.branch_taken_i  = 1'b0;
    bus.branch_target_i = 32'h0;
    bus.imem_rdata_i    = 32'h0;
    @(negedge clk);

    // Reset then sequential fetch from 0
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("seq0_instr", bus.if_id_instr_o, 32'h2001_0005);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("seq1_instr", bus.if_id_instr_o, 32'h2002_000A);
    check("seq_count", 32'(bus.fetch_count_o), 32'd2);

    // Stall hold at pc=8, then resume
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("stall_pc", bus.imem_addr_o, 32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Branch beats stall, target gets word-aligned
    step(1'b0, 1'b1, 1'b1, 32'h0000_0043);
    check("br_pc", bus.imem_addr_o, 32'h40);

    // HALT at 0x40, then bubbles, then redirect out of HALTED
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("halt_instr", bus.if_id_instr_o, HALT);
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0080);
    check("resume_pc", bus.imem_addr_o, 32'h80);

    // Saturation of the narrow counter
    repeat (20) step(1'b0, 1'b0, 1'b0, 32'h0);
    check("sat_count", 32'(bus.fetch_count_o), 32'hF);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_pc4", bus.if_id_pc_plus4_o, 32'h0);

    // Reset while halted and stalled
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 10,
           (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0) | ($urandom() & 32'h0000_03FF));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
